psoc_audio_fifo: RTL and testbench

PSOC_AUDIO_FIFO -- requirements
Module: psoc_audio_fifo

---
 rtl/psoc_audio_fifo.sv | 103 ++++++++++
 tb/tb_psoc_audio_fifo.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/psoc_audio_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// psoc_audio_fifo: first-word fall-through stereo sample FIFO feeding the DAC.
// Revision 1.0
// ----------------------------------------------------------------------------
module psoc_audio_fifo #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned LOW_WATER = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_valid,
  input  logic [47:0]                wr_data,
  output logic                       wr_ready,
  output logic [47:0]                fifo_data,
  input  logic                       fifo_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       low_water,
  output logic                       underrun,
  input  logic                       underrun_clr
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] LOW_WATER_LVL = (AW + 1)'(LOW_WATER);

  logic [47:0] mem_q [DEPTH];

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0] level_q,  level_d;
  logic        underrun_q, underrun_d;

  logic empty;
  logic full;
  logic do_wr;
  logic do_pop;
  logic pop_empty;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign do_wr     = wr_valid && !full && !flush;
  assign do_pop    = fifo_ready && !empty;
  assign pop_empty = fifo_ready && empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    underrun_d = underrun_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_wr)  wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_wr, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end

    // A new underrun event wins over a coincident clear.
    if (pop_empty) begin
      underrun_d = 1'b1;
    end else if (underrun_clr) begin
      underrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      underrun_q <= underrun_d;
    end
  end

  // Storage is not reset; stale entries are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign wr_ready  = !full;
  assign fifo_data = empty ? 48'h0 : mem_q[rd_ptr_q[AW-1:0]];
  assign level     = level_q;
  assign low_water = (level_q <= LOW_WATER_LVL);
  assign underrun  = underrun_q;

endmodule
`default_nettype wire

// File: tb/tb_psoc_audio_fifo.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_psoc_audio_fifo: directed self-checking bench for psoc_audio_fifo.
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_psoc_audio_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_valid = 1'b0;
  logic [47:0] wr_data = '0;
  logic        wr_ready;
  logic [47:0] fifo_data;
  logic        fifo_ready = 1'b0;
  logic        flush = 1'b0;
  logic [4:0]  level;
  logic        low_water;
  logic        underrun;
  logic        underrun_clr = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  psoc_audio_fifo #(.DEPTH(16), .LOW_WATER(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .fifo_data    (fifo_data),
    .fifo_ready   (fifo_ready),
    .flush        (flush),
    .level        (level),
    .low_water    (low_water),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] data_of(input int i);
    logic [15:0] t;
    t = i[15:0];
    return {8'hA0, t, 8'h5F, ~t};
  endfunction

  task automatic push(input logic [47:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic pop();
    fifo_ready = 1'b1;
    tick();
    fifo_ready = 1'b0;
  endtask

  initial begin
    // Reset state, sampled while rst is still low
    #12;
    check("rst_wr_ready",  48'(wr_ready),  48'd1);
    check("rst_fifo_data", fifo_data,      48'h0);
    check("rst_low_water", 48'(low_water), 48'd1);
    check("rst_level",     48'(level),     48'd0);
    check("rst_underrun",  48'(underrun),  48'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();

    // Single write, FWFT visibility
    push(48'hAAAAAA_555555);
    check("w1_data",      fifo_data,      48'hAAAAAA_555555);
    check("w1_level",     48'(level),     48'd1);
    check("w1_low_water", 48'(low_water), 48'd1);
    pop();
    check("w1_pop_level", 48'(level),     48'd0);
    check("w1_pop_data",  fifo_data,      48'h0);

    // Fill to full, then a rejected write coinciding with a pop
    for (int i = 0; i < 16; i++) push(data_of(i));
    check("full_wr_ready",  48'(wr_ready),  48'd0);
    check("full_level",     48'(level),     48'd16);
    check("full_low_water", 48'(low_water), 48'd0);
    check("full_head",      fifo_data,      data_of(0));
    wr_valid = 1'b1; wr_data = 48'hDEAD_BEEF_0000; fifo_ready = 1'b1;
    tick();
    wr_valid = 1'b0; fifo_ready = 1'b0;
    check("w17_level", 48'(level), 48'd15);
    check("w17_head",  fifo_data,  data_of(1));
    for (int k = 1; k < 16; k++) begin
      check("drain_data",  fifo_data,      data_of(k));
      check("drain_lowwm", 48'(low_water), ((16 - k) <= 4) ? 48'd1 : 48'd0);
      pop();
    end
    check("drain_level", 48'(level), 48'd0);
    check("drain_empty", fifo_data,  48'h0);

    // Underrun: set, clear, clear colliding with a new event
    pop();
    check("ur_set",   48'(underrun),  48'd1);
    check("ur_data",  fifo_data,      48'h0);
    check("ur_level", 48'(level),     48'd0);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    check("ur_clr", 48'(underrun), 48'd0);
    underrun_clr = 1'b1; fifo_ready = 1'b1; tick();
    underrun_clr = 1'b0; fifo_ready = 1'b0;
    check("ur_clr_vs_event", 48'(underrun), 48'd1);
    // Pop on empty with a same-cycle write: write still lands
    wr_valid = 1'b1; wr_data = 48'h123456_789ABC; fifo_ready = 1'b1;
    tick();
    wr_valid = 1'b0; fifo_ready = 1'b0;
    check("ur_wr_level", 48'(level), 48'd1);
    check("ur_wr_data",  fifo_data,  48'h123456_789ABC);
    underrun_clr = 1'b1; tick(); underrun_clr = 1'b0;
    pop();
    check("ur_wr_drain", 48'(level), 48'd0);

    // Simultaneous write and pop at level 8
    for (int i = 0; i < 8; i++) push(data_of(32 + i));
    check("l8_level", 48'(level), 48'd8);
    wr_valid = 1'b1; wr_data = data_of(40); fifo_ready = 1'b1;
    tick();
    wr_valid = 1'b0; fifo_ready = 1'b0;
    check("l8_wrpop_level", 48'(level), 48'd8);
    check("l8_wrpop_head",  fifo_data,  data_of(33));
    for (int k = 33; k <= 40; k++) begin
      check("l8_order", fifo_data, data_of(k));
      pop();
    end
    check("l8_empty", 48'(level), 48'd0);

    // Pointer wrap: 40 writes, pops start once three entries are queued
    for (int i = 0; i < 40; i++) begin
      wr_valid = 1'b1; wr_data = data_of(100 + i); fifo_ready = (i >= 3);
      tick();
      check("wrap_level", 48'(level), (i < 3) ? 48'(i + 1) : 48'd3);
      check("wrap_head",  fifo_data,  data_of(100 + ((i < 3) ? 0 : i - 2)));
    end
    wr_valid = 1'b0; fifo_ready = 1'b0;
    for (int k = 37; k < 40; k++) begin
      check("wrap_tail", fifo_data, data_of(100 + k));
      pop();
    end
    check("wrap_empty", 48'(level), 48'd0);

    // Asynchronous reset mid-stream at level 5
    for (int i = 0; i < 5; i++) push(data_of(200 + i));
    check("mr_level5", 48'(level), 48'd5);
    #2 rst = 1'b0;
    #1;
    check("mr_level",    48'(level),    48'd0);
    check("mr_data",     fifo_data,     48'h0);
    check("mr_wr_ready", 48'(wr_ready), 48'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    push(48'hCAFE00_00F00D);
    check("mr_first_data",  fifo_data,  48'hCAFE00_00F00D);
    check("mr_first_level", 48'(level), 48'd1);

    // Flush at level 3 overrides a same-cycle write and pop
    push(data_of(300));
    push(data_of(301));
    check("fl_level3", 48'(level), 48'd3);
    flush = 1'b1; wr_valid = 1'b1; wr_data = data_of(302); fifo_ready = 1'b1;
    tick();
    flush = 1'b0; wr_valid = 1'b0; fifo_ready = 1'b0;
    check("fl_level",    48'(level),    48'd0);
    check("fl_data",     fifo_data,     48'h0);
    check("fl_wr_ready", 48'(wr_ready), 48'd1);
    check("fl_underrun", 48'(underrun), 48'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
